// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC codes, FSM states, reset PC.
// Optional build macro IF_ALIGN_CHECK_EN enables misaligned-target detection in if_fetch_unit.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [3:0] NPC_PLUS4  = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_JUMP   = 4'd2;
    localparam logic [3:0] NPC_JR     = 4'd3;
    localparam logic [3:0] NPC_JALR   = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// Combinational next-PC selection from the held PC, instruction index fields and rs.
module if_npc_calc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic [31:0] rs_data,
    input  logic [3:0]  npc_op,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_BRANCH: npc = pc_plus4 + br_off;
            NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JR,
            NPC_JALR:   npc = rs_data;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, held instruction.
// Define IF_ALIGN_CHECK_EN to add the sticky fetch_err output and HALT on misaligned targets.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       npc_op,
    input  logic [31:0]      rs_data,
    input  logic             commit,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             instr_valid,
`ifdef IF_ALIGN_CHECK_EN
    output logic             fetch_err,
`endif
    output logic [CNT_W-1:0] retired
);

    fetch_state_e     state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             valid_q;
    logic             req_q;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      npc;
    logic [31:0]      pc_d;

    if_npc_calc u_npc_calc (
        .pc      (pc_q),
        .instr   (instr_q[25:0]),
        .rs_data (rs_data),
        .npc_op  (npc_op),
        .npc     (npc)
    );

`ifdef IF_ALIGN_CHECK_EN
    logic err_q;
    assign pc_d      = npc;
    assign fetch_err = err_q;
`else
    assign pc_d = npc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            retired_q <= '0;
`ifdef IF_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (commit) begin
                        pc_q      <= pc_d;
                        valid_q   <= 1'b0;
                        retired_q <= retired_q + CNT_W'(1);
`ifdef IF_ALIGN_CHECK_EN
                        // A misaligned target still retires the instruction but stops fetching
                        if (npc[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end
`else
                        state_q   <= ST_REQ;
                        req_q     <= 1'b1;
`endif
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_valid = valid_q;
    assign retired     = retired_q;

endmodule
